cpu_state_sequencer: RTL and testbench



---
 rtl/cpu_state_sequencer_pkg.sv | 23 ++
 rtl/cpu_state_sequencer_if.sv | 28 ++
 rtl/cpu_state_sequencer_stall_watchdog.sv | 47 ++++
 rtl/cpu_state_sequencer.sv | 99 +++++++++
 tb/tb_cpu_state_sequencer.sv | 138 +++++++++++++
 5 files changed

// File: rtl/cpu_state_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : State encodings shared by the sequencer and the control unit.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] STATE_HALT   = 4'd0;
    localparam logic [3:0] STATE_FETCH  = 4'd1;
    localparam logic [3:0] STATE_DECODE = 4'd2;
    localparam logic [3:0] STATE_EXEC1  = 4'd3;
    localparam logic [3:0] STATE_EXEC2  = 4'd4;

    // States in which an Avalon waitrequest holds the sequencer in place.
    function automatic logic is_stall_state(input state_t s);
        return (s == STATE_FETCH) || (s == STATE_EXEC1) || (s == STATE_EXEC2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_state_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_state_sequencer_if
// Brief    : Bus wait/halt inputs and state/status outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface cpu_state_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             waitrequest;
    logic             halt_req;
    logic [3:0]       state;
    logic             active;
    logic             fault;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] cycles;

    modport master (
        input  waitrequest, halt_req,
        output state, active, fault, retired, cycles
    );

    modport slave (
        output waitrequest, halt_req,
        input  state, active, fault, retired, cycles
    );
endinterface
`default_nettype wire

// File: rtl/cpu_state_sequencer_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : stall_watchdog
// Brief    : Counts consecutive stalled cycles and flags expiry at the limit.
// Revision : 1.0
// ============================================================================
module stall_watchdog #(
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    output logic expire_o
);
    generate
        if (WAIT_TIMEOUT > 0) begin : g_wdt
            localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
            localparam logic [CW-1:0] c_LIMIT = CW'(WAIT_TIMEOUT - 1);

            logic [CW-1:0] wait_cnt_q;
            logic [CW-1:0] wait_cnt_d;

            // Saturates at the limit; any non-stalled cycle restarts the count.
            always_comb begin
                wait_cnt_d = wait_cnt_q;
                if (!stall_i) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != c_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end

            assign expire_o = stall_i && (wait_cnt_q == c_LIMIT);
        end else begin : g_nowdt
            assign expire_o = 1'b0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/cpu_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_state_sequencer
// Brief    : Multi-cycle HALT/FETCH/DECODE/EXEC1/EXEC2 sequencer with stall
//            watchdog and retired/cycle counters.
// Revision : 1.0
// ============================================================================
import cpu_pkg::*;

module cpu_state_sequencer #(
    parameter int CNT_W        = 32,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_state_sequencer_if.master bus
);
    state_t           state_q,   state_d;
    logic             boot_q;
    logic             active_q,  active_d;
    logic             fault_q,   fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] cycles_q,  cycles_d;

    logic w_stall;
    logic w_expire;

    assign w_stall = bus.waitrequest && is_stall_state(state_q);

    stall_watchdog #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .stall_i  (w_stall),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        cycles_d  = active_q ? cycles_q + CNT_W'(1) : cycles_q;

        if (boot_q) begin
            state_d  = STATE_FETCH;
            active_d = 1'b1;
        end else if (w_expire) begin
            // Expiry only happens with waitrequest high, so it always wins over halt_req.
            state_d  = STATE_HALT;
            active_d = 1'b0;
            fault_d  = 1'b1;
        end else begin
            case (state_q)
                STATE_FETCH:  if (!bus.waitrequest) state_d = STATE_DECODE;
                STATE_DECODE: state_d = STATE_EXEC1;
                STATE_EXEC1:  if (!bus.waitrequest) state_d = STATE_EXEC2;
                STATE_EXEC2: begin
                    if (!bus.waitrequest) begin
                        retired_d = retired_q + CNT_W'(1);
                        if (bus.halt_req) begin
                            state_d  = STATE_HALT;
                            active_d = 1'b0;
                        end else begin
                            state_d = STATE_FETCH;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STATE_HALT;
            boot_q    <= 1'b1;
            active_q  <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            boot_q    <= 1'b0;
            active_q  <= active_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.active  = active_q;
    assign bus.fault   = fault_q;
    assign bus.retired = retired_q;
    assign bus.cycles  = cycles_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_state_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_state_sequencer
// Brief    : Directed self-checking bench for cpu_state_sequencer.
// Revision : 1.0
// ============================================================================
module tb_cpu_state_sequencer;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    cpu_state_sequencer_if #(.CNT_W(32)) bus_if ();

    cpu_state_sequencer #(
        .CNT_W        (32),
        .WAIT_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk(input string tag, input int st, input logic act, input logic flt,
                       input int ret, input int cyc);
        check({tag, ".state"},   64'(bus_if.state),   64'(st));
        check({tag, ".active"},  64'(bus_if.active),  64'(act));
        check({tag, ".fault"},   64'(bus_if.fault),   64'(flt));
        check({tag, ".retired"}, 64'(bus_if.retired), 64'(ret));
        check({tag, ".cycles"},  64'(bus_if.cycles),  64'(cyc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b1;
        bus_if.waitrequest = 1'b0;
        bus_if.halt_req    = 1'b0;

        // 1: reset then a clean instruction
        step(); step();
        chk("rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(); chk("t1_fetch",  1, 1, 0, 0, 0);
        step(); chk("t1_decode", 2, 1, 0, 0, 1);
        step(); chk("t1_exec1",  3, 1, 0, 0, 2);
        step(); chk("t1_exec2",  4, 1, 0, 0, 3);
        step(); chk("t1_refetch",1, 1, 0, 1, 4);

        // 2: three stalled cycles in FETCH
        bus_if.waitrequest = 1'b1;
        step(); chk("t2_st1", 1, 1, 0, 1, 5);
        step(); chk("t2_st2", 1, 1, 0, 1, 6);
        step(); chk("t2_st3", 1, 1, 0, 1, 7);
        bus_if.waitrequest = 1'b0;
        step(); chk("t2_decode", 2, 1, 0, 1, 8);
        step(); chk("t2_exec1",  3, 1, 0, 1, 9);
        step(); chk("t2_exec2",  4, 1, 0, 1, 10);

        // 3: halt_req with EXEC2 stalled two cycles
        bus_if.halt_req    = 1'b1;
        bus_if.waitrequest = 1'b1;
        step(); chk("t3_st1", 4, 1, 0, 1, 11);
        step(); chk("t3_st2", 4, 1, 0, 1, 12);
        bus_if.waitrequest = 1'b0;
        step(); chk("t3_halt", 0, 0, 0, 2, 13);
        for (int i = 0; i < 20; i++) begin
            bus_if.waitrequest = i[0];
            bus_if.halt_req    = i[1];
            step();
            chk("t3_hold", 0, 0, 0, 2, 13);
        end

        // 6: halt_req held early has no effect until EXEC2
        bus_if.waitrequest = 1'b0;
        bus_if.halt_req    = 1'b0;
        reset = 1'b1;
        step(); chk("t6_rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(); chk("t6_fetch", 1, 1, 0, 0, 0);
        bus_if.halt_req    = 1'b1;
        bus_if.waitrequest = 1'b1;
        step(); chk("t6_fstall", 1, 1, 0, 0, 1);
        bus_if.waitrequest = 1'b0;
        step(); chk("t6_decode", 2, 1, 0, 0, 2);
        step(); chk("t6_exec1",  3, 1, 0, 0, 3);
        step(); chk("t6_exec2",  4, 1, 0, 0, 4);
        step(); chk("t6_halt",   0, 0, 0, 1, 5);

        // 4: watchdog expiry in EXEC1
        bus_if.halt_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(); chk("t4_fetch",  1, 1, 0, 0, 0);
        step(); chk("t4_decode", 2, 1, 0, 0, 1);
        step(); chk("t4_exec1",  3, 1, 0, 0, 2);
        bus_if.waitrequest = 1'b1;
        step(); chk("t4_w1", 3, 1, 0, 0, 3);
        step(); chk("t4_w2", 3, 1, 0, 0, 4);
        step(); chk("t4_w3", 3, 1, 0, 0, 5);
        step(); chk("t4_expire", 0, 0, 1, 0, 6);
        bus_if.waitrequest = 1'b0;
        step(); chk("t4_sticky", 0, 0, 1, 0, 6);

        // 5: reset during stalled EXEC2
        reset = 1'b1;
        step(); chk("t5_rst0", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(); step(); step(); step();
        chk("t5_exec2", 4, 1, 0, 0, 3);
        bus_if.waitrequest = 1'b1;
        step(); chk("t5_stall", 4, 1, 0, 0, 4);
        reset = 1'b1;
        step(); chk("t5_rst", 0, 0, 0, 0, 0);
        reset = 1'b0;
        bus_if.waitrequest = 1'b0;
        step(); chk("t5_boot", 1, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
